// File: rtl/mips64_pkg.sv
// Shared MIPS64 EX-stage definitions: op encoding bits, MDU FSM state codes, default width.
package mips64_pkg;

    localparam int XLEN_DEF = 64;

    // op[2:0] bit positions
    localparam int OP_DW  = 2;
    localparam int OP_DIV = 1;
    localparam int OP_U   = 0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 step: MSB-first shift-add multiply or restoring shift-subtract divide.
module mdu_step #(
    parameter int XLEN = 64
) (
    input  logic                is_div,
    input  logic [XLEN-1:0]     opnd,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     sh_in,
    output logic [2*XLEN-1:0]   acc_out,
    output logic [XLEN-1:0]     sh_out
);

    logic [XLEN:0]     trial;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] addend;

    always_comb begin
        trial   = {acc_in[XLEN-1:0], sh_in[XLEN-1]};
        diff    = trial - {1'b0, opnd};
        addend  = sh_in[XLEN-1] ? {{XLEN{1'b0}}, opnd} : '0;
        acc_out = '0;
        sh_out  = '0;
        if (is_div) begin
            // trial < 2*divisor, so diff's top bit is exactly the borrow
            if (!diff[XLEN]) begin
                acc_out = {{XLEN{1'b0}}, diff[XLEN-1:0]};
                sh_out  = {sh_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {{XLEN{1'b0}}, trial[XLEN-1:0]};
                sh_out  = {sh_in[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = {acc_in[2*XLEN-2:0], 1'b0} + addend;
            sh_out  = {sh_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS64 multiply/divide unit: IDLE->PREP->RUN->FIX->DONE, UNROLL steps per RUN cycle.
// UNROLL must be 1, 2 or 4 and divide XLEN/2.
module mdu_iter
    import mips64_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN / UNROLL + 1);

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   rs_q, rt_q, opnd_q, sh_q, hi_q, lo_q;
    logic [2*XLEN-1:0] acc_q;
    logic              pneg_q, rneg_q, dz_q;

    logic              dw;
    logic              sa, sb, dz;
    logic [HALF-1:0]   aw, bw;
    logic [XLEN-1:0]   a_mag, b_mag, a_sh, b_sh;

    function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] v);
        return {{HALF{v[HALF-1]}}, v};
    endfunction

    assign dw = op_q[OP_DW];

    // Operand conditioning: magnitudes, and MSB-aligned shift operand so word ops need only HALF steps
    always_comb begin
        sa    = ~op_q[OP_U] & (dw ? rs_q[XLEN-1] : rs_q[HALF-1]);
        sb    = ~op_q[OP_U] & (dw ? rt_q[XLEN-1] : rt_q[HALF-1]);
        aw    = sa ? -rs_q[HALF-1:0] : rs_q[HALF-1:0];
        bw    = sb ? -rt_q[HALF-1:0] : rt_q[HALF-1:0];
        a_mag = dw ? (sa ? -rs_q : rs_q) : {{HALF{1'b0}}, aw};
        b_mag = dw ? (sb ? -rt_q : rt_q) : {{HALF{1'b0}}, bw};
        a_sh  = dw ? a_mag : {aw, {HALF{1'b0}}};
        b_sh  = dw ? b_mag : {bw, {HALF{1'b0}}};
        dz    = dw ? (rt_q == '0) : (rt_q[HALF-1:0] == '0);
    end

    logic [UNROLL:0][2*XLEN-1:0] acc_c;
    logic [UNROLL:0][XLEN-1:0]   sh_c;

    assign acc_c[0] = acc_q;
    assign sh_c[0]  = sh_q;

    generate
        for (genvar g = 0; g < UNROLL; g++) begin : g_step
            mdu_step #(.XLEN(XLEN)) u_step (
                .is_div (op_q[OP_DIV]),
                .opnd   (opnd_q),
                .acc_in (acc_c[g]),
                .sh_in  (sh_c[g]),
                .acc_out(acc_c[g+1]),
                .sh_out (sh_c[g+1])
            );
        end
    endgenerate

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, raw_hi, raw_lo, fin_hi, fin_lo;

    always_comb begin
        prod   = pneg_q ? -acc_q : acc_q;
        quo    = pneg_q ? -sh_q : sh_q;
        rem    = rneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        raw_hi = '0;
        raw_lo = '0;
        if (op_q[OP_DIV]) begin
            if (dz_q) begin
                raw_hi = rs_q;
                raw_lo = '1;
            end else begin
                raw_hi = rem;
                raw_lo = quo;
            end
        end else if (dw) begin
            raw_hi = prod[2*XLEN-1:XLEN];
            raw_lo = prod[XLEN-1:0];
        end else begin
            raw_hi = {{HALF{1'b0}}, prod[XLEN-1:HALF]};
            raw_lo = prod[XLEN-1:0];
        end
        fin_hi = dw ? raw_hi : sext_w(raw_hi[HALF-1:0]);
        fin_lo = dw ? raw_lo : sext_w(raw_lo[HALF-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            opnd_q <= '0;
            sh_q   <= '0;
            acc_q  <= '0;
            pneg_q <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (flush && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (in_valid && !flush) begin
                    op_q  <= op;
                    rs_q  <= rs_val;
                    rt_q  <= rt_val;
                    state <= S_PREP;
                end
                S_PREP: begin
                    opnd_q <= op_q[OP_DIV] ? b_mag : a_mag;
                    sh_q   <= op_q[OP_DIV] ? a_sh : b_sh;
                    acc_q  <= '0;
                    pneg_q <= sa ^ sb;
                    rneg_q <= sa;
                    dz_q   <= dz;
                    cnt    <= dw ? CW'(XLEN / UNROLL) : CW'(HALF / UNROLL);
                    state  <= S_RUN;
                end
                S_RUN: begin
                    acc_q <= acc_c[UNROLL];
                    sh_q  <= sh_c[UNROLL];
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi_q  <= fin_hi;
                    lo_q  <= fin_lo;
                    state <= S_DONE;
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized checks of mdu_iter at UNROLL=1 and UNROLL=4.
module tb_mdu_iter;

    localparam logic [2:0] MULT   = 3'b000, MULTU  = 3'b001, DIV   = 3'b010, DIVU   = 3'b011;
    localparam logic [2:0] DMULT  = 3'b100, DMULTU = 3'b101, DDIV  = 3'b110, DDIVU  = 3'b111;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [63:0] rs_val, rt_val;
    logic        in_valid1, in_ready1, flush1, out_valid1, out_ready1, busy1;
    logic        in_valid4, in_ready4, flush4, out_valid4, out_ready4, busy4;
    logic [63:0] hi1, lo1, hi4, lo4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(64), .UNROLL(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush1), .out_valid(out_valid1),
        .out_ready(out_ready1), .hi(hi1), .lo(lo1), .busy(busy1)
    );

    mdu_iter #(.XLEN(64), .UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush4), .out_valid(out_valid4),
        .out_ready(out_ready4), .hi(hi4), .lo(lo4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Arithmetic reference built from language operators, with the architectural corner cases
    task automatic ref_model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                             output logic [63:0] h, output logic [63:0] l);
        logic signed [63:0]  as, bs;
        logic signed [31:0]  as32, bs32;
        logic signed [127:0] ps;
        logic signed [63:0]  ps64;
        logic [127:0]        pu;
        logic [63:0]         pu64;
        logic [31:0]         a32, b32;
        as = a; bs = b; a32 = a[31:0]; b32 = b[31:0]; as32 = a32; bs32 = b32;
        h = '0; l = '0;
        if (o[2]) begin
            if (o[1]) begin
                if (b == 64'd0) begin l = '1; h = a; end
                else if (o[0]) begin l = a / b; h = a % b; end
                else if (a == MIN64 && b == '1) begin l = MIN64; h = '0; end
                else begin l = as / bs; h = as % bs; end
            end else if (o[0]) begin
                pu = {64'd0, a} * {64'd0, b};
                h = pu[127:64]; l = pu[63:0];
            end else begin
                ps = 128'(as) * 128'(bs);
                h = ps[127:64]; l = ps[63:0];
            end
        end else begin
            if (o[1]) begin
                if (b32 == 32'd0) begin l = '1; h = sx(a32); end
                else if (o[0]) begin l = sx(a32 / b32); h = sx(a32 % b32); end
                else if (a32 == 32'h8000_0000 && b32 == '1) begin l = sx(a32); h = '0; end
                else begin l = sx(32'(as32 / bs32)); h = sx(32'(as32 % bs32)); end
            end else if (o[0]) begin
                pu64 = {32'd0, a32} * {32'd0, b32};
                h = sx(pu64[63:32]); l = sx(pu64[31:0]);
            end else begin
                ps64 = 64'(as32) * 64'(bs32);
                h = sx(ps64[63:32]); l = sx(ps64[31:0]);
            end
        end
    endtask

    // Issue on dut1 from #1 after an edge; operands are scrambled right after accept
    task automatic run1(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] h, output logic [63:0] l, output int lat);
        op = o; rs_val = a; rt_val = b; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0; op = ~o; rs_val = ~a; rt_val = ~b;
        lat = 0;
        while (out_valid1 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        h = hi1; l = lo1;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
    endtask

    initial begin
        logic [63:0] h, l, eh, el, a, b;
        logic [2:0]  o;
        int          lat, seen;

        rst = 1'b1; op = '0; rs_val = '0; rt_val = '0;
        in_valid1 = 0; flush1 = 0; out_ready1 = 0;
        in_valid4 = 0; flush4 = 0; out_ready4 = 0;
        #12;
        chk("rst_in_ready", in_ready1, 1);
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_hi", hi1, 0);
        chk("rst_lo", lo1, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        run1(DMULTU, '1, 64'd2, h, l, lat);
        chk("dmultu_lat", lat, 66);
        chk("dmultu_hi", h, 64'd1);
        chk("dmultu_lo", l, 64'hFFFF_FFFF_FFFF_FFFE);

        run1(MULT, 64'h1234_5678_8000_0000, 64'd2, h, l, lat);
        chk("mult_lat", lat, 34);
        chk("mult_hi", h, '1);
        chk("mult_lo", l, 64'd0);

        run1(DDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, h, l, lat);
        chk("ddiv_neg_lo", l, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("ddiv_neg_hi", h, '1);

        run1(DIVU, 64'd7, 64'd0, h, l, lat);
        chk("divu_dz_lo", l, '1);
        chk("divu_dz_hi", h, 64'd7);

        run1(DDIV, MIN64, '1, h, l, lat);
        chk("ddiv_ovf_lo", l, MIN64);
        chk("ddiv_ovf_hi", h, 64'd0);

        // UNROLL=4: latency, then result held stable while consumer stalls
        op = DIV; rs_val = 64'd100; rt_val = 64'd7; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (out_valid4 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        chk("u4_lat", lat, 10);
        chk("u4_lo", lo4, 64'd14);
        chk("u4_hi", hi4, 64'd2);
        repeat (5) @(posedge clk);
        #1;
        chk("u4_hold_valid", out_valid4, 1);
        chk("u4_hold_lo", lo4, 64'd14);
        chk("u4_hold_hi", hi4, 64'd2);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        chk("u4_drain_busy", busy4, 0);

        // Flush during RUN; last committed result is the DDIV overflow case
        op = DMULT; rs_val = 64'd3; rt_val = 64'd5; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("flush_pre_busy", busy1, 1);
        flush1 = 1'b1;
        @(posedge clk); #1;
        flush1 = 1'b0;
        chk("flush_busy", busy1, 0);
        chk("flush_in_ready", in_ready1, 1);
        chk("flush_out_valid", out_valid1, 0);
        chk("flush_hi_hold", hi1, 64'd0);
        chk("flush_lo_hold", lo1, MIN64);
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid1) seen = 1;
        end
        chk("flush_no_result", seen, 0);
        run1(DMULT, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, h, l, lat);
        chk("post_flush_lo", l, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("post_flush_hi", h, '1);

        // flush beats a same-cycle request in IDLE
        op = DDIV; rs_val = 64'd9; rt_val = 64'd3; in_valid1 = 1'b1; flush1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0; flush1 = 1'b0;
        chk("idle_flush_busy", busy1, 0);
        chk("idle_flush_in_ready", in_ready1, 1);

        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 3 == 1) b = 64'($urandom_range(1, 1000));
            if (i % 4 == 2) b = -b;
            run1(o, a, b, h, l, lat);
            ref_model(o, a, b, eh, el);
            chk($sformatf("rand%0d_op%0d_hi", i, o), h, eh);
            chk($sformatf("rand%0d_op%0d_lo", i, o), l, el);
        end

        // Asynchronous reset mid-RUN, applied away from any clock edge
        op = DDIVU; rs_val = 64'd1000; rt_val = 64'd3; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_in_ready", in_ready1, 1);
        chk("arst_busy", busy1, 0);
        chk("arst_out_valid", out_valid1, 0);
        chk("arst_hi", hi1, 0);
        chk("arst_lo", lo1, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
